pipe_hazard_ctrl: RTL and testbench

//  Pipeline hazard/control tracker between ID and the EX/MEM/WB stages. Carries per-stage

---
 rtl/pipe_pkg.sv | 24 ++
 rtl/pipe_hazard_ctrl_stage_tag_reg.sv | 33 +++
 rtl/pipe_hazard_ctrl.sv | 156 +++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared types for the ID/EX/MEM/WB hazard tracker: per-stage register tag slot and helpers.
package pipe_pkg;

    localparam int unsigned REG_W = 5;
    localparam logic [REG_W-1:0] REG_X0 = 5'd0;

    typedef struct packed {
        logic             valid;
        logic [REG_W-1:0] rs1;
        logic [REG_W-1:0] rs2;
        logic [REG_W-1:0] rd;
        logic             regwrite;
        logic             memread;
        logic             memacc;
    } stage_tag_t;

    localparam stage_tag_t TAG_BUBBLE = '0;

    // An empty slot must present x0 so the forwarder never matches it.
    function automatic logic [REG_W-1:0] tag_if_valid(input logic valid, input logic [REG_W-1:0] tag);
        return valid ? tag : REG_X0;
    endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_stage_tag_reg.sv
// One pipeline slot register for the tag tracker: hold wins over bubble, bubble wins over load.
module stage_tag_reg
    import pipe_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       hold_i,
    input  logic       bubble_i,
    input  stage_tag_t d_i,
    output stage_tag_t q_o
);

    stage_tag_t slot_q;
    stage_tag_t slot_d;

    always_comb begin
        slot_d = slot_q;
        if (!hold_i) begin
            slot_d = bubble_i ? TAG_BUBBLE : d_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            slot_q <= TAG_BUBBLE;
        end else begin
            slot_q <= slot_d;
        end
    end

    assign q_o = slot_q;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard/control tracker: carries register tags ID->EX->MEM->WB, detects load-use,
// freezes on a busy data memory, and keeps a saturating stall counter and a timeout flag.
module pipe_hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int unsigned CNT_W   = 32,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             ID_Valid_i,
    input  logic [4:0]       ID_Rs1_i,
    input  logic [4:0]       ID_Rs2_i,
    input  logic             ID_Rs1Used_i,
    input  logic             ID_Rs2Used_i,
    input  logic [4:0]       ID_Rd_i,
    input  logic             ID_RegWrite_i,
    input  logic             ID_MemRead_i,
    input  logic             ID_MemWrite_i,
    input  logic             Flush_i,
    input  logic             DMem_Ready_i,
    output logic [4:0]       EX_Rs1_o,
    output logic [4:0]       EX_Rs2_o,
    output logic             MEM_RegWrite_o,
    output logic [4:0]       MEM_Rd_o,
    output logic             WB_RegWrite_o,
    output logic [4:0]       WB_Rd_o,
    output logic             PC_Write_o,
    output logic             IFID_Write_o,
    output logic             IDEX_Bubble_o,
    output logic             Pipe_Freeze_o,
    output logic [CNT_W-1:0] Stall_Cnt_o,
    output logic             Mem_Err_o
);

    localparam int unsigned TO_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    stage_tag_t id_tag;
    stage_tag_t ex_q;
    stage_tag_t mem_q;
    stage_tag_t wb_q;

    logic freeze;
    logic load_use;
    logic ex_bubble;

    logic [CNT_W-1:0] stall_cnt_q;
    logic [CNT_W-1:0] stall_cnt_d;
    logic [TO_W-1:0]  to_cnt_q;
    logic [TO_W-1:0]  to_cnt_d;
    logic             mem_err_q;
    logic             mem_err_d;

    always_comb begin
        id_tag          = TAG_BUBBLE;
        id_tag.valid    = ID_Valid_i;
        id_tag.rs1      = ID_Rs1_i;
        id_tag.rs2      = ID_Rs2_i;
        id_tag.rd       = ID_Rd_i;
        id_tag.regwrite = ID_RegWrite_i;
        id_tag.memread  = ID_MemRead_i;
        id_tag.memacc   = ID_MemRead_i | ID_MemWrite_i;
    end

    // Hazard detection and pipe control; freeze outranks load-use, which outranks flush.
    always_comb begin
        freeze        = mem_q.valid & mem_q.memacc & ~DMem_Ready_i;
        load_use      = ID_Valid_i & ex_q.valid & ex_q.memread & (ex_q.rd != REG_X0) &
                        ((ID_Rs1Used_i & (ID_Rs1_i == ex_q.rd)) |
                         (ID_Rs2Used_i & (ID_Rs2_i == ex_q.rd)));
        PC_Write_o    = 1'b1;
        IFID_Write_o  = 1'b1;
        IDEX_Bubble_o = 1'b0;
        Pipe_Freeze_o = 1'b0;
        if (freeze) begin
            PC_Write_o    = 1'b0;
            IFID_Write_o  = 1'b0;
            Pipe_Freeze_o = 1'b1;
        end else if (load_use) begin
            PC_Write_o    = 1'b0;
            IFID_Write_o  = 1'b0;
            IDEX_Bubble_o = 1'b1;
        end else if (Flush_i) begin
            IDEX_Bubble_o = 1'b1;
        end
        ex_bubble = IDEX_Bubble_o;
    end

    stage_tag_reg u_ex_slot (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .hold_i   (freeze),
        .bubble_i (ex_bubble),
        .d_i      (id_tag),
        .q_o      (ex_q)
    );

    stage_tag_reg u_mem_slot (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .hold_i   (freeze),
        .bubble_i (1'b0),
        .d_i      (ex_q),
        .q_o      (mem_q)
    );

    // WB also holds on freeze so the forwarder keeps seeing the same producer.
    stage_tag_reg u_wb_slot (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .hold_i   (freeze),
        .bubble_i (1'b0),
        .d_i      (mem_q),
        .q_o      (wb_q)
    );

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (!PC_Write_o && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
        to_cnt_d  = '0;
        mem_err_d = mem_err_q;
        if (freeze) begin
            to_cnt_d = (to_cnt_q == TO_W'(TIMEOUT)) ? to_cnt_q : to_cnt_q + TO_W'(1);
            if ((TIMEOUT != 0) && (to_cnt_d == TO_W'(TIMEOUT))) begin
                mem_err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stall_cnt_q <= '0;
            to_cnt_q    <= '0;
            mem_err_q   <= 1'b0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            to_cnt_q    <= to_cnt_d;
            mem_err_q   <= mem_err_d;
        end
    end

    assign EX_Rs1_o       = tag_if_valid(ex_q.valid, ex_q.rs1);
    assign EX_Rs2_o       = tag_if_valid(ex_q.valid, ex_q.rs2);
    assign MEM_RegWrite_o = mem_q.valid & mem_q.regwrite;
    assign MEM_Rd_o       = tag_if_valid(mem_q.valid, mem_q.rd);
    assign WB_RegWrite_o  = wb_q.valid & wb_q.regwrite;
    assign WB_Rd_o        = tag_if_valid(wb_q.valid, wb_q.rd);
    assign Stall_Cnt_o    = stall_cnt_q;
    assign Mem_Err_o      = mem_err_q;

    logic unused_wb_fields;
    assign unused_wb_fields = ^{wb_q.rs1, wb_q.rs2, wb_q.memread, wb_q.memacc};

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: directed hazard scenarios plus random traffic against a slot-array model.
module tb_pipe_hazard_ctrl;

    localparam int unsigned CNT_W   = 4;
    localparam int unsigned TIMEOUT = 4;
    localparam int          CNT_MAX = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             id_v = 1'b0;
    logic [4:0]       id_rs1 = '0;
    logic [4:0]       id_rs2 = '0;
    logic             id_u1 = 1'b0;
    logic             id_u2 = 1'b0;
    logic [4:0]       id_rd = '0;
    logic             id_rw = 1'b0;
    logic             id_mr = 1'b0;
    logic             id_mw = 1'b0;
    logic             flush = 1'b0;
    logic             ready = 1'b1;

    logic [4:0]       ex_rs1, ex_rs2, mem_rd, wb_rd;
    logic             mem_rw, wb_rw, pc_w, ifid_w, bubble, frz, err;
    logic [CNT_W-1:0] stall_cnt;

    pipe_hazard_ctrl #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
        .clk_i(clk), .rst_i(rst),
        .ID_Valid_i(id_v), .ID_Rs1_i(id_rs1), .ID_Rs2_i(id_rs2),
        .ID_Rs1Used_i(id_u1), .ID_Rs2Used_i(id_u2), .ID_Rd_i(id_rd),
        .ID_RegWrite_i(id_rw), .ID_MemRead_i(id_mr), .ID_MemWrite_i(id_mw),
        .Flush_i(flush), .DMem_Ready_i(ready),
        .EX_Rs1_o(ex_rs1), .EX_Rs2_o(ex_rs2),
        .MEM_RegWrite_o(mem_rw), .MEM_Rd_o(mem_rd),
        .WB_RegWrite_o(wb_rw), .WB_Rd_o(wb_rd),
        .PC_Write_o(pc_w), .IFID_Write_o(ifid_w), .IDEX_Bubble_o(bubble),
        .Pipe_Freeze_o(frz), .Stall_Cnt_o(stall_cnt), .Mem_Err_o(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit v;
        int rs1, rs2, rd;
        bit rw, mr, ma;
    } slot_t;

    slot_t pipe[3];   // 0 = EX, 1 = MEM, 2 = WB
    int    m_stall = 0;
    int    m_run = 0;
    bit    m_err = 1'b0;
    bit    chk_en = 1'b0;
    int    checks = 0;
    int    errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input bit v, input logic [4:0] rs1, input logic [4:0] rs2, input bit u1,
                         input bit u2, input logic [4:0] rd, input bit rw, input bit mr,
                         input bit mw, input bit fl, input bit rdy);
        id_v = v; id_rs1 = rs1; id_rs2 = rs2; id_u1 = u1; id_u2 = u2; id_rd = rd;
        id_rw = rw; id_mr = mr; id_mw = mw; flush = fl; ready = rdy;
        #1;
    endtask

    task automatic nop(input bit rdy);
        drive(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, rdy);
    endtask

    // Compare every output against the model, then advance the model across one clock edge.
    task automatic tick();
        bit    fz, lu, stall;
        slot_t nx[3];
        slot_t id_s;
        slot_t empty;
        empty = '{default: 0};
        fz = pipe[1].v && pipe[1].ma && !ready;
        lu = id_v && pipe[0].v && pipe[0].mr && (pipe[0].rd != 0) &&
             ((id_u1 && (int'(id_rs1) == pipe[0].rd)) || (id_u2 && (int'(id_rs2) == pipe[0].rd)));
        stall = fz || lu;
        if (chk_en) begin
            chk("pc_write",   32'(pc_w),      32'(!stall));
            chk("ifid_write", 32'(ifid_w),    32'(!stall));
            chk("idex_bubble",32'(bubble),    32'(!fz && (lu || flush)));
            chk("freeze",     32'(frz),       32'(fz));
            chk("ex_rs1",     32'(ex_rs1),    pipe[0].v ? pipe[0].rs1 : 0);
            chk("ex_rs2",     32'(ex_rs2),    pipe[0].v ? pipe[0].rs2 : 0);
            chk("mem_rw",     32'(mem_rw),    32'(pipe[1].v && pipe[1].rw));
            chk("mem_rd",     32'(mem_rd),    pipe[1].v ? pipe[1].rd : 0);
            chk("wb_rw",      32'(wb_rw),     32'(pipe[2].v && pipe[2].rw));
            chk("wb_rd",      32'(wb_rd),     pipe[2].v ? pipe[2].rd : 0);
            chk("stall_cnt",  32'(stall_cnt), m_stall);
            chk("mem_err",    32'(err),       32'(m_err));
        end
        id_s.v = id_v; id_s.rs1 = int'(id_rs1); id_s.rs2 = int'(id_rs2); id_s.rd = int'(id_rd);
        id_s.rw = id_rw; id_s.mr = id_mr; id_s.ma = id_mr || id_mw;
        nx = pipe;
        if (!fz) begin
            for (int i = 2; i > 0; i--) nx[i] = pipe[i-1];
            nx[0] = (lu || flush) ? empty : id_s;
        end
        @(posedge clk);
        if (rst) begin
            for (int i = 0; i < 3; i++) pipe[i] = empty;
            m_stall = 0; m_run = 0; m_err = 1'b0;
        end else begin
            pipe = nx;
            if (stall && m_stall < CNT_MAX) m_stall++;
            m_run = fz ? m_run + 1 : 0;
            if (TIMEOUT != 0 && m_run >= int'(TIMEOUT)) m_err = 1'b1;
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1; nop(1'b1); tick(); rst = 1'b0;
    endtask

    int burst = 0;

    initial begin
        for (int i = 0; i < 3; i++) pipe[i] = '{default: 0};
        @(negedge clk);
        nop(1'b1); tick(); tick();
        rst = 1'b0; chk_en = 1'b1;

        // Reset state
        nop(1'b1);
        chk("rst_pc", 32'(pc_w), 32'd1);     chk("rst_ifid", 32'(ifid_w), 32'd1);
        chk("rst_bub", 32'(bubble), 32'd0);  chk("rst_frz", 32'(frz), 32'd0);
        chk("rst_cnt", 32'(stall_cnt), 32'd0); chk("rst_err", 32'(err), 32'd0);
        chk("rst_tags", 32'({ex_rs1, mem_rd, wb_rd}), 32'd0);
        tick();

        // lw x5 then add x6,x5,x1
        drive(1, 5'd2, 5'd0, 1, 0, 5'd5, 1, 1, 0, 0, 1); tick();
        drive(1, 5'd5, 5'd1, 1, 1, 5'd6, 1, 0, 0, 0, 1);
        chk("lu_pc", 32'(pc_w), 32'd0); chk("lu_bub", 32'(bubble), 32'd1); chk("lu_ifid", 32'(ifid_w), 32'd0);
        tick();
        drive(1, 5'd5, 5'd1, 1, 1, 5'd6, 1, 0, 0, 0, 1);
        chk("lu_memrd", 32'(mem_rd), 32'd5); chk("lu_exrs1", 32'(ex_rs1), 32'd0);
        chk("lu_pc2", 32'(pc_w), 32'd1); chk("lu_cnt", 32'(stall_cnt), 32'd1);
        tick();
        nop(1); chk("lu_exrs1b", 32'(ex_rs1), 32'd5); chk("lu_exrs2b", 32'(ex_rs2), 32'd1); tick();

        // lw x0 never stalls
        do_reset();
        drive(1, 5'd2, 5'd0, 1, 0, 5'd0, 1, 1, 0, 0, 1); tick();
        drive(1, 5'd0, 5'd0, 1, 1, 5'd7, 1, 0, 0, 0, 1);
        chk("x0_pc", 32'(pc_w), 32'd1); chk("x0_bub", 32'(bubble), 32'd0); tick();
        nop(1); chk("x0_cnt", 32'(stall_cnt), 32'd0); chk("x0_memrw", 32'(mem_rw), 32'd1); tick();

        // Three-cycle memory freeze
        do_reset();
        drive(1, 5'd1, 5'd2, 1, 1, 5'd3, 1, 0, 0, 0, 1); tick();
        drive(1, 5'd2, 5'd0, 1, 0, 5'd7, 1, 1, 0, 0, 1); tick();
        nop(1); tick();
        for (int k = 0; k < 3; k++) begin
            nop(0);
            chk("fz_frz", 32'(frz), 32'd1); chk("fz_pc", 32'(pc_w), 32'd0);
            chk("fz_bub", 32'(bubble), 32'd0); chk("fz_wbrd", 32'(wb_rd), 32'd3);
            chk("fz_memrd", 32'(mem_rd), 32'd7);
            tick();
        end
        nop(1); chk("fz_rel", 32'(frz), 32'd0); chk("fz_cnt", 32'(stall_cnt), 32'd3); tick();
        nop(1); chk("fz_wbrd2", 32'(wb_rd), 32'd7); tick();

        // Load-use wins over flush; flush honoured next cycle
        do_reset();
        drive(1, 5'd2, 5'd0, 1, 0, 5'd5, 1, 1, 0, 0, 1); tick();
        drive(1, 5'd5, 5'd0, 1, 0, 5'd6, 1, 0, 0, 1, 1);
        chk("luf_bub", 32'(bubble), 32'd1); chk("luf_pc", 32'(pc_w), 32'd0); tick();
        drive(1, 5'd5, 5'd0, 1, 0, 5'd6, 1, 0, 0, 1, 1);
        chk("fl_bub", 32'(bubble), 32'd1); chk("fl_pc", 32'(pc_w), 32'd1); chk("fl_ifid", 32'(ifid_w), 32'd1);
        tick();
        nop(1); chk("fl_exrs1", 32'(ex_rs1), 32'd0); chk("fl_wbrd", 32'(wb_rd), 32'd5);
        chk("fl_cnt", 32'(stall_cnt), 32'd1); tick();

        // Memory timeout with TIMEOUT=4
        do_reset();
        drive(1, 5'd2, 5'd0, 1, 0, 5'd7, 1, 1, 0, 0, 1); tick();
        nop(1); tick();
        for (int k = 1; k <= 6; k++) begin
            nop(0); chk("to_err", 32'(err), (k >= 5) ? 32'd1 : 32'd0); tick();
        end
        nop(1); chk("to_sticky", 32'(err), 32'd1); chk("to_frz", 32'(frz), 32'd0); tick();
        nop(1); chk("to_sticky2", 32'(err), 32'd1); chk("to_cnt", 32'(stall_cnt), 32'd6); tick();

        // Reset in the middle of a freeze
        drive(1, 5'd2, 5'd0, 1, 0, 5'd9, 1, 1, 0, 0, 1); tick();
        nop(1); tick();
        nop(0); tick(); nop(0); tick();
        rst = 1'b1; nop(0); chk("mr_frz", 32'(frz), 32'd1); tick(); rst = 1'b0;
        nop(0);
        chk("mr_tags", 32'({ex_rs1, ex_rs2, mem_rd, wb_rd}), 32'd0); chk("mr_pc", 32'(pc_w), 32'd1);
        chk("mr_frz0", 32'(frz), 32'd0); chk("mr_cnt", 32'(stall_cnt), 32'd0); chk("mr_err", 32'(err), 32'd0);
        tick();

        // Random traffic over a small register set to provoke hazards
        for (int n = 0; n < 3000; n++) begin
            bit rdy, mr;
            rst = ($urandom_range(0, 199) == 0);
            if (burst > 0) begin
                rdy = 1'b0; burst--;
            end else if ($urandom_range(0, 99) == 0) begin
                rdy = 1'b0; burst = 6;
            end else begin
                rdy = ($urandom_range(0, 3) != 0);
            end
            mr = ($urandom_range(0, 2) == 0);
            drive($urandom_range(0, 3) != 0, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                  $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, 5'($urandom_range(0, 3)),
                  $urandom_range(0, 1) == 1, mr, !mr && ($urandom_range(0, 3) == 0),
                  $urandom_range(0, 7) == 0, rdy);
            tick();
        end
        rst = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
